square_note_seq: RTL and testbench



---
 rtl/square_note_seq.sv | 193 +++++++++++++++++++
 tb/tb_square_note_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_note_seq.sv
// Note sequencer: queues {period, duration} notes and plays them frame by frame
// into the square-wave divider, with an optional silent gap between notes.
module square_note_seq #(
    parameter int WIDTH      = 16,
    parameter int DUR_W      = 16,
    parameter int DEPTH_LOG2 = 3,
    parameter int GAP_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [WIDTH-1:0]      wr_period,
    input  logic [DUR_W-1:0]      wr_dur,
    input  logic                  flush,
    input  logic                  enable,
    input  logic                  frame,
    output logic [WIDTH-1:0]      period,
    output logic                  gate,
    output logic                  busy,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int GAP_W = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    logic [WIDTH-1:0] mem_period [DEPTH];
    logic [DUR_W-1:0] mem_dur    [DEPTH];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [DUR_W-1:0]      rem_q, rem_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [WIDTH-1:0]      period_q, period_d;
    logic                  gate_q, gate_d;
    logic                  done_q, done_d;
    logic                  full_q, full_d;
    logic                  busy_q, busy_d;

    logic                  wr_acc;
    logic                  pop;
    logic                  frame_en;
    logic                  have_note;
    logic [WIDTH-1:0]      head_period;
    logic [DUR_W-1:0]      head_dur;

    assign head_period = mem_period[rd_ptr_q];
    assign head_dur    = mem_dur[rd_ptr_q];
    assign frame_en    = frame && enable;
    assign have_note   = (level_q != '0);
    assign wr_acc      = wr && !full_q && !flush;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        period_d = period_q;
        gate_d   = gate_q;
        done_d   = 1'b0;
        pop      = 1'b0;

        if (flush) begin
            state_d  = S_IDLE;
            gate_d   = 1'b0;
            period_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pop = have_note;
                end
                S_PLAY: begin
                    if (frame_en) begin
                        if (rem_q > DUR_W'(1)) begin
                            rem_d = rem_q - DUR_W'(1);
                        end else if (GAP_FRAMES > 0) begin
                            gate_d  = 1'b0;
                            gap_d   = GAP_W'(GAP_FRAMES);
                            state_d = S_GAP;
                        end else if (have_note) begin
                            pop = 1'b1;
                        end else begin
                            gate_d   = 1'b0;
                            period_d = '0;
                            state_d  = S_IDLE;
                            done_d   = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (frame_en) begin
                        if (gap_q > GAP_W'(1)) begin
                            gap_d = gap_q - GAP_W'(1);
                        end else if (have_note) begin
                            pop = 1'b1;
                        end else begin
                            period_d = '0;
                            state_d  = S_IDLE;
                            done_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (pop) begin
                period_d = head_period;
                gate_d   = (head_period != '0);
                rem_d    = (head_dur == '0) ? DUR_W'(1) : head_dur;
                state_d  = S_PLAY;
            end
        end
    end

    // Queue bookkeeping; a flush discards everything including a same-edge write
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_acc && !pop) begin
                level_d = level_q + 1'b1;
            end else if (!wr_acc && pop) begin
                level_d = level_q - 1'b1;
            end
        end
        full_d = (level_d == (DEPTH_LOG2 + 1)'(DEPTH));
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_period[wr_ptr_q] <= wr_period;
            mem_dur[wr_ptr_q]    <= wr_dur;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rem_q    <= '0;
            gap_q    <= '0;
            period_q <= '0;
            gate_q   <= 1'b0;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            period_q <= period_d;
            gate_q   <= gate_d;
            done_q   <= done_d;
            full_q   <= full_d;
            busy_q   <= busy_d;
        end
    end

    assign period = period_q;
    assign gate   = gate_q;
    assign busy   = busy_q;
    assign full   = full_q;
    assign level  = level_q;
    assign done   = done_q;

endmodule

// File: tb/tb_square_note_seq.sv
// Scoreboard bench for square_note_seq: one instance with a 2-frame gap,
// one with no gap; output events are checked against queued expectations.
module tb_square_note_seq;

    typedef struct packed {
        logic [15:0] p;
        logic        g;
        logic        d;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  wr = 2'b00;
    logic [15:0] wr_period = '0;
    logic [15:0] wr_dur = '0;
    logic        flush = 1'b0;
    logic        enable = 1'b1;
    logic        frame = 1'b0;

    logic [15:0] per  [2];
    logic        gate [2];
    logic        busy [2];
    logic        full [2];
    logic [3:0]  lvl  [2];
    logic        done [2];

    int   n_tests = 0;
    int   n_fail = 0;
    logic mon_on = 1'b0;
    ev_t  q0[$];
    ev_t  q1[$];
    ev_t  prev [2];

    always #5 clk = ~clk;

    square_note_seq #(.GAP_FRAMES(2)) u_g2 (
        .clk(clk), .reset(reset), .wr(wr[0]),
        .wr_period(wr_period), .wr_dur(wr_dur),
        .flush(flush), .enable(enable), .frame(frame),
        .period(per[0]), .gate(gate[0]), .busy(busy[0]),
        .full(full[0]), .level(lvl[0]), .done(done[0])
    );

    square_note_seq #(.GAP_FRAMES(0)) u_g0 (
        .clk(clk), .reset(reset), .wr(wr[1]),
        .wr_period(wr_period), .wr_dur(wr_dur),
        .flush(flush), .enable(enable), .frame(frame),
        .period(per[1]), .gate(gate[1]), .busy(busy[1]),
        .full(full[1]), .level(lvl[1]), .done(done[1])
    );

    function automatic ev_t mk(input logic [15:0] p, input logic g,
                               input logic d);
        ev_t e;
        e.p = p;
        e.g = g;
        e.d = d;
        return e;
    endfunction

    task automatic push(input int i, input ev_t e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic check_ev(input int i, input ev_t a);
        ev_t e;
        n_tests++;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_fail++;
            $display("FAIL unexpected_event inst%0d: got p=%0d g=%0b d=%0b, expected none",
                     i, a.p, a.g, a.d);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL event inst%0d: got p=%0d g=%0b d=%0b, expected p=%0d g=%0b d=%0b",
                         i, a.p, a.g, a.d, e.p, e.g, e.d);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t cur;
        for (int i = 0; i < 2; i++) begin
            cur = mk(per[i], gate[i], done[i]);
            if (mon_on && cur !== prev[i]) check_ev(i, cur);
            prev[i] = cur;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            repeat (9) tick();
        end
    endtask

    task automatic wr_note(input int i, input logic [15:0] p,
                           input logic [15:0] d);
        wr[i] = 1'b1;
        wr_period = p;
        wr_dur = d;
        tick();
        wr = 2'b00;
    endtask

    task automatic end_test(input string name);
        repeat (3) tick();
        chk({name, "_q0_drained"}, q0.size(), 0);
        chk({name, "_q1_drained"}, q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_period", per[0], 0);
        chk("rst_gate", gate[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_full", full[0], 0);
        chk("rst_level", lvl[0], 0);
        chk("rst_done", done[0], 0);
        reset = 1'b0;
        tick();
        mon_on = 1'b1;

        // single note with gap
        push(0, mk(90, 1, 0));
        push(0, mk(90, 0, 0));
        push(0, mk(0, 0, 1));
        push(0, mk(0, 0, 0));
        wr_note(0, 90, 3);
        chk("t1_level_after_wr", lvl[0], 1);
        tick();
        chk("t1_level_after_pop", lvl[0], 0);
        chk("t1_busy", busy[0], 1);
        chk("t1_period", per[0], 90);
        frames(3);
        chk("t1_gap_busy", busy[0], 1);
        frames(2);
        chk("t1_idle_busy", busy[0], 0);
        end_test("t1");

        // back-to-back, no gap; second note has dur 0 (plays one frame)
        push(1, mk(90, 1, 0));
        push(1, mk(120, 1, 0));
        push(1, mk(0, 0, 0));
        push(1, mk(0, 0, 1));
        push(1, mk(0, 0, 0));
        wr_note(1, 90, 2);
        wr_note(1, 120, 0);
        wr_note(1, 0, 2);
        chk("t2_level", lvl[1], 2);
        frames(4);
        chk("t2_rest_busy", busy[1], 1);
        frames(1);
        chk("t2_end_busy", busy[1], 0);
        end_test("t2");

        // overflow while paused, then drain
        enable = 1'b0;
        for (int k = 0; k < 9; k++) begin
            push(0, mk(16'(100 + k), 1, 0));
            push(0, mk(16'(100 + k), 0, 0));
        end
        push(0, mk(0, 0, 1));
        push(0, mk(0, 0, 0));
        for (int k = 0; k < 9; k++) wr_note(0, 16'(100 + k), 1);
        chk("t3_level_full", lvl[0], 8);
        chk("t3_full", full[0], 1);
        wr_note(0, 16'd555, 1);
        chk("t3_level_drop", lvl[0], 8);
        chk("t3_period_held", per[0], 100);
        frames(2);
        chk("t3_paused_period", per[0], 100);
        enable = 1'b1;
        frames(30);
        chk("t3_drained_level", lvl[0], 0);
        end_test("t3");

        // pause mid-note
        push(0, mk(90, 1, 0));
        push(0, mk(90, 0, 0));
        push(0, mk(0, 0, 1));
        push(0, mk(0, 0, 0));
        wr_note(0, 90, 4);
        tick();
        frames(2);
        enable = 1'b0;
        frames(5);
        chk("t4_pause_gate", gate[0], 1);
        chk("t4_pause_busy", busy[0], 1);
        enable = 1'b1;
        frames(1);
        chk("t4_third_gate", gate[0], 1);
        frames(1);
        chk("t4_fourth_gate", gate[0], 0);
        frames(2);
        end_test("t4");

        // flush with concurrent write
        push(0, mk(90, 1, 0));
        push(0, mk(0, 0, 0));
        wr_note(0, 90, 4);
        wr_note(0, 50, 2);
        frames(1);
        flush = 1'b1;
        wr[0] = 1'b1;
        wr_period = 77;
        wr_dur = 3;
        tick();
        flush = 1'b0;
        wr = 2'b00;
        chk("t5_level", lvl[0], 0);
        chk("t5_busy", busy[0], 0);
        chk("t5_gate", gate[0], 0);
        chk("t5_done", done[0], 0);
        frames(3);
        chk("t5_still_idle", busy[0], 0);
        end_test("t5");

        // async reset mid-gap with three queued notes
        push(0, mk(90, 1, 0));
        push(0, mk(90, 0, 0));
        push(0, mk(0, 0, 0));
        wr_note(0, 90, 1);
        wr_note(0, 60, 1);
        wr_note(0, 61, 1);
        wr_note(0, 62, 1);
        frames(1);
        chk("t6_level_q3", lvl[0], 3);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_period", per[0], 0);
        chk("t6_rst_gate", gate[0], 0);
        chk("t6_rst_busy", busy[0], 0);
        chk("t6_rst_level", lvl[0], 0);
        chk("t6_rst_full", full[0], 0);
        chk("t6_rst_done", done[0], 0);
        tick();
        reset = 1'b0;
        frames(3);
        chk("t6_after_gate", gate[0], 0);
        chk("t6_after_busy", busy[0], 0);
        end_test("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
